// File: rtl/controlador_compuerta.sv
// Parking-gate controller: registered Moore FSM with a wrong-PIN attempt counter and tail-gating lockout.
// Optional open-gate timeout is compiled in when ABIERTO_TIMEOUT_EN is defined.
module controlador_compuerta #(
  parameter logic [7:0] PIN_CORRECTO   = 8'h08,
  parameter int         MAX_INTENTOS   = 3
`ifdef ABIERTO_TIMEOUT_EN
  , parameter int       TIMEOUT_CICLOS = 16
`endif
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Pin,
  input  logic       Vehiculo,
  input  logic       Termino,
  output logic       Cerrado,
  output logic       Abierto,
  output logic       Alarma,
  output logic       Bloqueo
);

  typedef enum logic [1:0] {
    ESPERA    = 2'd0,
    PIN       = 2'd1,
    ABIERTA   = 2'd2,
    BLOQUEADO = 2'd3
  } estado_t;

  localparam logic [2:0] MAX_LIMITE = 3'(MAX_INTENTOS);

  estado_t    estado, estado_sig;
  logic [1:0] intentos, intentos_sig;
  logic       alarma_sig;
  logic       pin_prev;
  logic       intento;
  logic       pin_ok;
  logic [2:0] intentos_mas_uno;
  logic       cerrado_sig, abierto_sig, alarma_out_sig, bloqueo_sig;

  // An attempt is the first edge of a nonzero Pin; holding the value does not re-trigger.
  assign intento          = (Pin != 8'h00) && !pin_prev;
  assign pin_ok           = (Pin == PIN_CORRECTO);
  assign intentos_mas_uno = {1'b0, intentos} + 3'd1;

`ifdef ABIERTO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);

  logic [TW-1:0] temporizador;
  logic          tiempo_agotado;

  assign tiempo_agotado = (temporizador == TW'(TIMEOUT_CICLOS - 1));

  // Counts edges spent in ABIERTA; restarts on entry and while a vehicle is present.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      temporizador <= '0;
    end else if ((estado != ABIERTA) || Vehiculo) begin
      temporizador <= '0;
    end else begin
      temporizador <= temporizador + 1'b1;
    end
  end
`endif

  // State, counters and the registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      estado   <= ESPERA;
      intentos <= 2'd0;
      pin_prev <= 1'b0;
      Cerrado  <= 1'b1;
      Abierto  <= 1'b0;
      Alarma   <= 1'b0;
      Bloqueo  <= 1'b0;
    end else begin
      estado   <= estado_sig;
      intentos <= intentos_sig;
      pin_prev <= (Pin != 8'h00);
      Cerrado  <= cerrado_sig;
      Abierto  <= abierto_sig;
      Alarma   <= alarma_out_sig;
      Bloqueo  <= bloqueo_sig;
    end
  end

  // Next-state logic; Alarma doubles as the sticky alarm flag.
  always_comb begin
    estado_sig   = estado;
    intentos_sig = intentos;
    alarma_sig   = Alarma;
    case (estado)
      ESPERA: begin
        if (Vehiculo) begin
          estado_sig = PIN;
        end
      end
      PIN: begin
        if (intento) begin
          if (pin_ok) begin
            estado_sig   = ABIERTA;
            intentos_sig = 2'd0;
            alarma_sig   = 1'b0;
          end else begin
            intentos_sig = (intentos == 2'd3) ? 2'd3 : intentos + 2'd1;
            if (intentos_mas_uno >= MAX_LIMITE) begin
              alarma_sig = 1'b1;
            end
          end
        end else if (!Vehiculo && !Alarma) begin
          estado_sig   = ESPERA;
          intentos_sig = 2'd0;
        end
      end
      ABIERTA: begin
        if (Termino) begin
          if (Vehiculo) begin
            estado_sig = BLOQUEADO;
            alarma_sig = 1'b1;
          end else begin
            estado_sig = ESPERA;
          end
        end
`ifdef ABIERTO_TIMEOUT_EN
        else if (tiempo_agotado && !Vehiculo) begin
          estado_sig = ESPERA;
        end
`endif
      end
      BLOQUEADO: begin
        if (intento && pin_ok) begin
          estado_sig   = ESPERA;
          intentos_sig = 2'd0;
          alarma_sig   = 1'b0;
        end
      end
      default: begin
        estado_sig = ESPERA;
      end
    endcase
  end

  // Output decode from the next state so outputs change on the same edge as the state.
  always_comb begin
    cerrado_sig    = (estado_sig != ABIERTA);
    abierto_sig    = (estado_sig == ABIERTA);
    bloqueo_sig    = (estado_sig == BLOQUEADO);
    alarma_out_sig = alarma_sig || (estado_sig == BLOQUEADO);
  end

endmodule

// File: tb/tb_controlador_compuerta.sv
// Directed bench for controlador_compuerta: expected outputs are queued with each stimulus
// and popped for comparison one edge later, outputs packed as {Cerrado, Abierto, Alarma, Bloqueo}.
module tb_controlador_compuerta;

  logic       Clk;
  logic       Reset;
  logic [7:0] Pin;
  logic       Vehiculo;
  logic       Termino;
  logic       Cerrado, Abierto, Alarma, Bloqueo;

  typedef struct {
    logic [3:0] salidas;
    string      tag;
  } esperado_t;

  esperado_t scoreboard[$];
  int vectors     = 0;
  int miscompares = 0;

  localparam logic [3:0] IDLE   = 4'b1000;
  localparam logic [3:0] OPEN   = 4'b0100;
  localparam logic [3:0] ALARM  = 4'b1010;
  localparam logic [3:0] LOCKED = 4'b1011;

  controlador_compuerta dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Pin      (Pin),
    .Vehiculo (Vehiculo),
    .Termino  (Termino),
    .Cerrado  (Cerrado),
    .Abierto  (Abierto),
    .Alarma   (Alarma),
    .Bloqueo  (Bloqueo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput();
    esperado_t e;
    logic [3:0] obs;
    obs = {Cerrado, Abierto, Alarma, Bloqueo};
    vectors++;
    if (scoreboard.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_empty: observed %b, required a queued entry", obs);
    end else begin
      e = scoreboard.pop_front();
      assert (obs === e.salidas) else begin
        miscompares++;
        $error("[TB] FAIL %s: observed CAAlB=%b, expected %b", e.tag, obs, e.salidas);
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] p, input logic v, input logic t,
                               input logic [3:0] exp, input string tag);
    esperado_t e;
    @(negedge Clk);
    Pin      = p;
    Vehiculo = v;
    Termino  = t;
    e.salidas = exp;
    e.tag     = tag;
    scoreboard.push_back(e);
    @(posedge Clk);
    #1;
    checkOutput();
  endtask

  task automatic pushImmediate(input logic [3:0] exp, input string tag);
    esperado_t e;
    e.salidas = exp;
    e.tag     = tag;
    scoreboard.push_back(e);
  endtask

  initial begin
    Reset    = 1'b1;
    Pin      = 8'h00;
    Vehiculo = 1'b0;
    Termino  = 1'b0;
    #7;
    pushImmediate(IDLE, "reset_values");
    checkOutput();
    #5;
    Reset = 1'b0;

    applyStimulus(8'h00, 1'b0, 1'b0, IDLE, "idle_0");
    applyStimulus(8'h00, 1'b0, 1'b0, IDLE, "idle_1");

    // Normal pass: arrive, correct PIN, vehicle passes.
    applyStimulus(8'h00, 1'b1, 1'b0, IDLE, "veh_arrive");
    applyStimulus(8'h08, 1'b1, 1'b0, OPEN, "pin_ok_opens");
    applyStimulus(8'h00, 1'b1, 1'b0, OPEN, "open_hold");
    applyStimulus(8'h00, 1'b0, 1'b1, IDLE, "pass_done");
    applyStimulus(8'h00, 1'b0, 1'b0, IDLE, "idle_after_pass");

    // Three wrong PINs raise a sticky alarm that a correct PIN clears.
    applyStimulus(8'h00, 1'b1, 1'b0, IDLE,  "veh_arrive_2");
    applyStimulus(8'h01, 1'b1, 1'b0, IDLE,  "wrong_1");
    applyStimulus(8'h00, 1'b1, 1'b0, IDLE,  "gap_1");
    applyStimulus(8'h01, 1'b1, 1'b0, IDLE,  "wrong_2");
    applyStimulus(8'h00, 1'b1, 1'b0, IDLE,  "gap_2");
    applyStimulus(8'h01, 1'b1, 1'b0, ALARM, "wrong_3_alarm");
    applyStimulus(8'h00, 1'b0, 1'b0, ALARM, "alarm_sticky_noveh");
    applyStimulus(8'h00, 1'b0, 1'b0, ALARM, "alarm_stays_pin");
    applyStimulus(8'h08, 1'b0, 1'b0, OPEN,  "attempt_priority_clears");

    // Tail-gating lockout: wrong PIN ignored, correct PIN unlocks.
    applyStimulus(8'h00, 1'b1, 1'b0, OPEN,   "open_wait");
    applyStimulus(8'h00, 1'b1, 1'b1, LOCKED, "tailgate_block");
    applyStimulus(8'h01, 1'b1, 1'b0, LOCKED, "blocked_wrong_ignored");
    applyStimulus(8'h00, 1'b0, 1'b0, LOCKED, "blocked_hold");
    applyStimulus(8'h08, 1'b0, 1'b0, IDLE,   "blocked_unlock");
    applyStimulus(8'h00, 1'b0, 1'b0, IDLE,   "idle_after_unlock");
    applyStimulus(8'h08, 1'b0, 1'b0, IDLE,   "espera_ignores_pin");
    applyStimulus(8'h00, 1'b0, 1'b0, IDLE,   "espera_release");

    // Held PIN counts once; leaving PIN clears the counter.
    applyStimulus(8'h00, 1'b1, 1'b0, IDLE, "veh_arrive_3");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'h01, 1'b1, 1'b0, IDLE, "held_pin_once");
    end
    applyStimulus(8'h00, 1'b1, 1'b0, IDLE, "held_release");
    applyStimulus(8'h01, 1'b1, 1'b0, IDLE, "second_attempt_no_alarm");
    applyStimulus(8'h00, 1'b0, 1'b0, IDLE, "leave_clears_count");
    applyStimulus(8'h00, 1'b1, 1'b0, IDLE, "veh_arrive_4");
    applyStimulus(8'h01, 1'b1, 1'b0, IDLE,  "after_clear_1");
    applyStimulus(8'h00, 1'b1, 1'b0, IDLE,  "gap_3");
    applyStimulus(8'h01, 1'b1, 1'b0, IDLE,  "after_clear_2");
    applyStimulus(8'h00, 1'b1, 1'b0, IDLE,  "gap_4");
    applyStimulus(8'h01, 1'b1, 1'b0, ALARM, "after_clear_3_alarm");

    // Open, tail-gate into lockout, then reset asynchronously mid-cycle.
    applyStimulus(8'h00, 1'b1, 1'b0, ALARM,  "gap_5");
    applyStimulus(8'h08, 1'b1, 1'b0, OPEN,   "reopen");
    applyStimulus(8'h00, 1'b1, 1'b1, LOCKED, "tailgate_again");
    @(negedge Clk);
    Pin      = 8'h00;
    Vehiculo = 1'b0;
    Termino  = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    pushImmediate(IDLE, "async_reset_in_block");
    checkOutput();
    #4;
    Reset = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0, IDLE, "after_reset_0");
    applyStimulus(8'h00, 1'b0, 1'b0, IDLE, "after_reset_1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
